// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares the single execute-stage ALU between the main pipeline EXE stage
//   (requester 0) and the auxiliary address/branch-target unit (requester 1).
//   Requester 0 has priority; requester 1 is force-granted once it has waited
//   STARVE_LIMIT consecutive cycles. The ALU result is registered and returned
//   one cycle after the grant, tagged with the owning requester. The block also
//   owns the architectural {Z,C,N,V} flag register, which feeds the ALU carry-in.
//
// Handshake: a requester raises rN_req with its cmd/operands/S bit and holds
//   them until rN_gnt is seen high in the same cycle. The grant is combinational.
//   The response (rsp_valid, one cycle wide) lands on the following edge.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   r0_req/cmd/op1/op2/s         requester 0 request, command, operands, set-flags
//   r1_req/cmd/op1/op2/s         requester 1 request, command, operands, set-flags
//   r0_gnt, r1_gnt               combinational grants (one-hot or zero)
//   alu_in1, alu_in2             ALU operands from the granted requester
//   alu_command                  ALU command from the granted requester
//   alu_cin                      ALU carry-in, the current C flag
//   alu_status, alu_out          ALU {Z,C,N,V} status and result
//   rsp_valid, rsp_id, rsp_data  registered response strobe, owner, result
//   flags                        architectural flag register {Z,C,N,V}
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic [3:0]  r0_cmd,
    input  logic [31:0] r0_op1,
    input  logic [31:0] r0_op2,
    input  logic        r0_s,
    input  logic        r1_req,
    input  logic [3:0]  r1_cmd,
    input  logic [31:0] r1_op1,
    input  logic [31:0] r1_op2,
    input  logic        r1_s,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_cin,
    output logic [3:0]  alu_command,
    input  logic [3:0]  alu_status,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  flags
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1100;
    localparam logic [3:0] CMD_TST = 4'b1110;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;
    logic             starved;
    logic             any_gnt;
    logic             gnt_s;
    logic [3:0]       gnt_cmd;
    logic [3:0]       flags_next;
    logic [3:0]       flags_zn;

    // Grants are forced low while reset is asserted.
    assign starved = (cnt == LIMIT);
    assign r1_gnt  = rst_n & r1_req & (~r0_req | starved);
    assign r0_gnt  = rst_n & r0_req & ~r1_gnt;
    assign any_gnt = r0_gnt | r1_gnt;

    // Carry-in comes from the flag register before this cycle's update.
    assign alu_cin = flags[2];

    always_comb begin
        alu_command = 4'b0000;
        alu_in1     = '0;
        alu_in2     = '0;
        gnt_s       = 1'b0;
        gnt_cmd     = 4'b0000;
        if (r1_gnt) begin
            alu_command = r1_cmd;
            alu_in1     = r1_op1;
            alu_in2     = r1_op2;
            gnt_s       = r1_s;
            gnt_cmd     = r1_cmd;
        end else if (r0_gnt) begin
            alu_command = r0_cmd;
            alu_in1     = r0_op1;
            alu_in2     = r0_op2;
            gnt_s       = r0_s;
            gnt_cmd     = r0_cmd;
        end
    end

    // Logical ops touch only Z and N; C and V carry over from before.
    assign flags_zn = {alu_status[3], flags[2], alu_status[1], flags[0]};

    always_comb begin
        flags_next = flags;
        if (any_gnt) begin
            case (gnt_cmd)
                CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                    if (gnt_s) flags_next = alu_status;
                end
                CMD_CMP: flags_next = alu_status;
                CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
                    if (gnt_s) flags_next = flags_zn;
                end
                CMD_TST: flags_next = flags_zn;
                default: flags_next = flags;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (r1_req && !r1_gnt) begin
            if (!starved) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            flags     <= 4'b0000;
        end else begin
            rsp_valid <= any_gnt;
            flags     <= flags_next;
            if (any_gnt) begin
                rsp_id   <= r1_gnt;
                rsp_data <= alu_out;
            end
        end
    end

endmodule
